avalon_clr_ram: RTL and testbench

- Parametrised Avalon-MM single-port on-chip RAM slave, successor to the fixed 1024x32 altsyncram memory slave in the CPU system.
- Inferred RAM array with byte enables, explicit `readdatavalid` pipeline, `waitrequest` backpressure and a hardware clear engine that zeroes the array after reset or on request.
- Sits on the Nios/CPU data master as scratch or buffer RAM.

---
 rtl/avalon_clr_ram_if.sv | 28 ++
 rtl/avalon_clr_ram.sv | 117 +++++++++++
 tb/tb_avalon_clr_ram.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_clr_ram_if.sv
// Avalon-MM slave bus bundle for avalon_clr_ram: request signals driven by the
// master, response signals driven by the RAM slave.
interface avalon_clr_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_clr_ram.sv
// Avalon-MM single-port RAM slave with byte enables, pipelined readdatavalid and a
// clear engine. Define AVALON_CLR_RAM_OUTREG_EN to add a second output register (latency 2).
module avalon_clr_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_clken,
    input  logic            i_clear_req,
    output logic            o_clearing,
    avalon_clr_ram_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef AVALON_CLR_RAM_OUTREG_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                         r_state;
    logic [IDX_W-1:0]               r_clr_cnt;
    logic [DATA_W-1:0]              r_mem [DEPTH];
    logic [STAGES-1:0]              r_vld_pipe;
    logic [STAGES-1:0][DATA_W-1:0]  r_data_pipe;

    logic              w_busy;
    logic              w_accept;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              w_we;
    logic [IDX_W-1:0]  w_widx;
    logic [BE_W-1:0]   w_wbe;
    logic [DATA_W-1:0] w_wdata;

    // Addresses at or beyond DEPTH never alias onto implemented words.
    assign w_in_range = (33'(bus.address) < 33'(DEPTH));
    assign w_idx      = bus.address[IDX_W-1:0];
    assign w_busy     = !i_reset_n || !i_clken || (r_state == S_CLEAR);
    assign w_accept   = bus.chipselect && !w_busy;
    assign w_wr_acc   = w_accept && bus.write;
    assign w_rd_acc   = w_accept && bus.read && !bus.write;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else if (i_clken) begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state   <= S_IDLE;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_clear_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Single write port shared by the clear engine and bus writes.
    always_comb begin
        w_we    = 1'b0;
        w_widx  = w_idx;
        w_wbe   = bus.byteenable;
        w_wdata = bus.writedata;
        if (i_reset_n && i_clken && (r_state == S_CLEAR)) begin
            w_we    = 1'b1;
            w_widx  = r_clr_cnt;
            w_wbe   = '1;
            w_wdata = '0;
        end else if (w_wr_acc && w_in_range) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_wbe[b]) r_mem[w_widx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    // Data stages load only behind a valid so readdata holds between reads.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_vld_pipe  <= '0;
            r_data_pipe <= '0;
        end else if (i_clken) begin
            r_vld_pipe <= (r_vld_pipe << 1) | STAGES'(w_rd_acc);
            if (w_rd_acc) r_data_pipe[0] <= w_in_range ? r_mem[w_idx] : '0;
            for (int s = 1; s < STAGES; s++) begin
                if (r_vld_pipe[s-1]) r_data_pipe[s] <= r_data_pipe[s-1];
            end
        end
    end

    assign bus.readdata      = i_reset_n ? r_data_pipe[STAGES-1] : '0;
    assign bus.readdatavalid = i_reset_n && i_clken && r_vld_pipe[STAGES-1];
    assign bus.waitrequest   = w_busy;
    assign o_clearing        = !i_reset_n || (r_state == S_CLEAR);
endmodule

// File: tb/tb_avalon_clr_ram.sv
// Bench for avalon_clr_ram: per-cycle reference model check, a vector table and
// hand-written clear/stall/back-to-back sequences, then randomized traffic.
module tb_avalon_clr_ram;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;
`ifdef AVALON_CLR_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset_n, clken, clear_req, clearing;
    always #5 clk = ~clk;

    avalon_clr_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    avalon_clr_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_clken     (clken),
        .i_clear_req (clear_req),
        .o_clearing  (clearing),
        .bus         (bus)
    );

    // Reference model: whole-array view, clear countdown, queue of pending reads.
    logic [31:0] m_mem [DEPTH];
    int          m_clear_left;
    logic [31:0] q_data[$];
    int          q_age[$];
    logic [31:0] obs_q[$];
    logic        s_wait, s_rdv;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct {
        int          op;    // 0 write, 1 read, 2 read+write
        int          addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] want;
    } vec_t;
    vec_t tbl[14];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endfunction

    task automatic check_outputs();
        logic ev;
        logic ew;
        ev = reset_n && clken && (q_age.size() > 0) && (q_age[0] == LAT);
        ew = !reset_n || !clken || (m_clear_left > 0);
        check("waitrequest", 32'(bus.waitrequest), 32'(ew));
        check("clearing", 32'(clearing), 32'(!reset_n || (m_clear_left > 0)));
        check("readdatavalid", 32'(bus.readdatavalid), 32'(ev));
        if (ev) check("readdata", bus.readdata, q_data[0]);
        s_wait = bus.waitrequest;
        s_rdv  = bus.readdatavalid;
        if (bus.readdatavalid === 1'b1) obs_q.push_back(bus.readdata);
    endtask

    task automatic model_edge();
        int a;
        a = int'(bus.address);
        if (!reset_n) begin
            q_data.delete();
            q_age.delete();
            m_clear_left = DEPTH;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else if (clken) begin
            if (q_age.size() > 0 && q_age[0] == LAT) begin
                void'(q_data.pop_front());
                void'(q_age.pop_front());
            end
            foreach (q_age[i]) q_age[i] = q_age[i] + 1;
            if (m_clear_left > 0) begin
                m_clear_left--;
            end else begin
                if (bus.chipselect) begin
                    if (bus.write) begin
                        if (a < DEPTH)
                            for (int b = 0; b < 4; b++)
                                if (bus.byteenable[b]) m_mem[a][b*8 +: 8] = bus.writedata[b*8 +: 8];
                    end else if (bus.read) begin
                        q_data.push_back((a < DEPTH) ? m_mem[a] : 32'h0);
                        q_age.push_back(1);
                    end
                end
                if (clear_req) begin
                    m_clear_left = DEPTH;
                    foreach (m_mem[i]) m_mem[i] = '0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        clear_req      = 1'b0;
    endtask

    task automatic req(input logic r, input logic w, input int a, input logic [3:0] be, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read       = r;
        bus.write      = w;
        bus.address    = ADDR_W'(a);
        bus.byteenable = be;
        bus.writedata  = d;
        tick();
        idle();
    endtask

    task automatic rd_check(input string name, input int a, input logic [31:0] want);
        int lat;
        obs_q.delete();
        req(1'b1, 1'b0, a, 4'h0, 32'h0);
        lat = 0;
        while (obs_q.size() == 0 && lat < 10) begin
            tick();
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(LAT));
        check({name, "_data"}, (obs_q.size() > 0) ? obs_q[0] : 32'hxxxxxxxx, want);
    endtask

    task automatic count_clear(output int n, input int pulse_at);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            clear_req = (k == pulse_at);
            tick();
            if (s_wait) n++;
            else break;
        end
        clear_req = 1'b0;
    endtask

    initial begin
        int n;
        foreach (m_mem[i]) m_mem[i] = '0;
        m_clear_left = DEPTH;
        reset_n = 1'b0;
        clken   = 1'b1;
        bus.address    = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;
        idle();

        tbl[0]  = '{0, 5,  4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{0, 5,  4'h5, 32'h11223344, 32'h0};
        tbl[2]  = '{1, 5,  4'h0, 32'h0,        32'hDE22BE44};
        tbl[3]  = '{0, 7,  4'h0, 32'h12345678, 32'h0};
        tbl[4]  = '{1, 7,  4'h0, 32'h0,        32'h0};
        tbl[5]  = '{2, 7,  4'hF, 32'h00000055, 32'h0};
        tbl[6]  = '{1, 7,  4'h0, 32'h0,        32'h00000055};
        tbl[7]  = '{0, 20, 4'hF, 32'hCAFEF00D, 32'h0};
        tbl[8]  = '{1, 20, 4'h0, 32'h0,        32'h0};
        tbl[9]  = '{1, 4,  4'h0, 32'h0,        32'h0};
        tbl[10] = '{0, 15, 4'hF, 32'h12345678, 32'h0};
        tbl[11] = '{1, 15, 4'h0, 32'h0,        32'h12345678};
        tbl[12] = '{0, 0,  4'h8, 32'hAB000000, 32'h0};
        tbl[13] = '{1, 0,  4'h0, 32'h0,        32'hAB000000};

        // Post-reset clear length and all-zero contents.
        repeat (3) tick();
        reset_n = 1'b1;
        count_clear(n, -1);
        check("post_reset_clear_len", 32'(n), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) rd_check($sformatf("zero%0d", a), a, 32'h0);

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            case (tbl[i].op)
                0: req(1'b0, 1'b1, tbl[i].addr, tbl[i].be, tbl[i].wd);
                1: rd_check($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].want);
                default: begin
                    obs_q.delete();
                    req(1'b1, 1'b1, tbl[i].addr, tbl[i].be, tbl[i].wd);
                    repeat (LAT + 2) tick();
                    check($sformatf("tbl%0d_rw_novalid", i), 32'(obs_q.size()), 32'h0);
                end
            endcase
        end

        // Back-to-back reads, then readdata holdover.
        req(1'b0, 1'b1, 1, 4'hF, 32'hA);
        req(1'b0, 1'b1, 2, 4'hF, 32'hB);
        req(1'b0, 1'b1, 3, 4'hF, 32'hC);
        obs_q.delete();
        for (int a = 1; a <= 3; a++) begin
            bus.chipselect = 1'b1;
            bus.read       = 1'b1;
            bus.address    = ADDR_W'(a);
            tick();
        end
        idle();
        repeat (LAT + 2) tick();
        check("b2b_count", 32'(obs_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_data%0d", i), (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx, 32'hA + 32'(i));
        repeat (3) tick();
        check("holdover", bus.readdata, 32'hC);

        // clken stall with a read in flight.
        obs_q.delete();
        req(1'b1, 1'b0, 5, 4'h0, 32'h0);
        clken = 1'b0;
        repeat (3) begin
            tick();
            check("stall_rdv", 32'(s_rdv), 32'h0);
            check("stall_wait", 32'(s_wait), 32'h1);
        end
        clken = 1'b1;
        n = 0;
        while (obs_q.size() == 0 && n < 10) begin
            tick();
            n++;
        end
        check("stall_lat", 32'(n), 32'(LAT));
        check("stall_data", (obs_q.size() > 0) ? obs_q[0] : 32'hxxxxxxxx, 32'hDE22BE44);

        // clear_req with a read in the same cycle, reset at clear word 8, ignored clear_req.
        req(1'b0, 1'b1, 3, 4'hF, 32'hFF);
        obs_q.delete();
        clear_req = 1'b1;
        req(1'b1, 1'b0, 3, 4'h0, 32'h0);
        repeat (8) tick();
        check("pre_clear_read", (obs_q.size() > 0) ? obs_q[0] : 32'hxxxxxxxx, 32'hFF);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        count_clear(n, 4);
        check("restart_clear_len", 32'(n), 32'(DEPTH));
        rd_check("after_clear_addr3", 3, 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            reset_n        = ($urandom_range(0, 299) != 0);
            clken          = ($urandom_range(0, 7) != 0);
            clear_req      = ($urandom_range(0, 149) == 0);
            bus.chipselect = ($urandom_range(0, 9) < 7);
            bus.read       = 1'($urandom);
            bus.write      = 1'($urandom);
            bus.address    = ADDR_W'($urandom_range(0, 19));
            bus.byteenable = 4'($urandom);
            bus.writedata  = $urandom;
            tick();
        end
        idle();
        reset_n = 1'b1;
        clken   = 1'b1;
        repeat (DEPTH + 5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
